// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, collects CDB results, retires in program order.
// Optional operand bypass from completed entries and the live CDB is enabled by defining ROB_BYPASS_EN.
module reorder_buffer #(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dc_valid,
   input  logic [5:0]  dc_rd,
   output logic [5:0]  rob_free_entry,
   output logic        rob_full,
   input  logic        cdb_valid,
   input  logic [5:0]  cdb_tag,
   input  logic [31:0] cdb_data,
   input  logic        cdb_mispred,
   input  logic [31:0] cdb_target,
   input  logic [5:0]  lookup_tag1,
   input  logic [5:0]  lookup_tag2,
   output logic [32:0] lookup_data1,
   output logic [32:0] lookup_data2,
   output logic        we,
   output logic [5:0]  write_reg,
   output logic [5:0]  write_tag,
   output logic [31:0] write_data,
   output logic        mispred,
   output logic [31:0] redirect_pc
);

   localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [AW-1:0]      head;
   logic [AW-1:0]      tail;
   logic [6:0]         count;
   logic [ENTRIES-1:0] valid;
   logic [ENTRIES-1:0] done;
   logic [ENTRIES-1:0] mp;
   logic [5:0]         rd_mem     [ENTRIES];
   logic [31:0]        data_mem   [ENTRIES];
   logic [31:0]        target_mem [ENTRIES];

   logic          dispatch;
   logic          cdb_hit;
   logic          commit;
   logic          flush;
   logic [AW-1:0] cdb_idx;

   assign cdb_idx        = cdb_tag[AW-1:0];
   assign rob_full       = (count == 7'(ENTRIES));
   assign rob_free_entry = 6'(tail);
   assign dispatch       = dc_valid && !rob_full;
   // Tags with bits above the pointer width never name a real entry.
   assign cdb_hit        = cdb_valid && ((cdb_tag >> AW) == 6'd0) && valid[cdb_idx];
   assign commit         = (count != 7'd0) && done[head];
   assign flush          = commit && mp[head];

   always_comb begin
      we          = 1'b0;
      write_reg   = 6'd0;
      write_tag   = 6'd0;
      write_data  = 32'd0;
      mispred     = 1'b0;
      redirect_pc = 32'd0;
      if (commit) begin
         we         = 1'b1;
         write_reg  = rd_mem[head];
         write_tag  = 6'(head);
         write_data = data_mem[head];
         if (flush) begin
            mispred     = 1'b1;
            redirect_pc = target_mem[head];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= 7'd0;
         valid <= '0;
         done  <= '0;
         mp    <= '0;
      end else begin
         if (dispatch) begin
            valid[tail] <= 1'b1;
            done[tail]  <= 1'b0;
            mp[tail]    <= 1'b0;
            tail        <= tail + AW'(1);
         end
         if (cdb_hit) begin
            done[cdb_idx] <= 1'b1;
            mp[cdb_idx]   <= cdb_mispred;
         end
         if (commit) begin
            valid[head] <= 1'b0;
            done[head]  <= 1'b0;
            mp[head]    <= 1'b0;
            head        <= head + AW'(1);
         end
         case ({dispatch, commit})
            2'b10:   count <= count + 7'd1;
            2'b01:   count <= count - 7'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: payload arrays carry no reset; valid/done gate every read, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (dispatch) rd_mem[tail] <= dc_rd;
      if (cdb_hit) begin
         data_mem[cdb_idx]   <= cdb_data;
         target_mem[cdb_idx] <= cdb_target;
      end
   end

`ifdef ROB_BYPASS_EN
   function automatic logic [32:0] lookup(input logic [5:0] t);
      logic [AW-1:0] i;
      i = t[AW-1:0];
      if (cdb_valid && cdb_tag == t) return {1'b0, cdb_data};
      if (((t >> AW) == 6'd0) && valid[i] && done[i]) return {1'b0, data_mem[i]};
      return {1'b1, 32'd0};
   endfunction

   assign lookup_data1 = lookup(lookup_tag1);
   assign lookup_data2 = lookup(lookup_tag2);
`else
   logic unused_lookup;
   assign unused_lookup = ^{lookup_tag1, lookup_tag2};
   assign lookup_data1  = {1'b1, 32'd0};
   assign lookup_data2  = {1'b1, 32'd0};
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table for in-order commit, plus full/wrap, flush and reset sequences.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        dc_valid;
   logic [5:0]  dc_rd;
   logic [5:0]  rob_free_entry;
   logic        rob_full;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        cdb_mispred;
   logic [31:0] cdb_target;
   logic [5:0]  lookup_tag1;
   logic [5:0]  lookup_tag2;
   logic [32:0] lookup_data1;
   logic [32:0] lookup_data2;
   logic        we;
   logic [5:0]  write_reg;
   logic [5:0]  write_tag;
   logic [31:0] write_data;
   logic        mispred;
   logic [31:0] redirect_pc;

   int tests = 0;
   int fails = 0;

   localparam logic [32:0] PENDING = 33'h1_0000_0000;

   reorder_buffer #(.ENTRIES(64)) dut (
      .clk(clk), .reset(reset),
      .dc_valid(dc_valid), .dc_rd(dc_rd),
      .rob_free_entry(rob_free_entry), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
      .lookup_tag1(lookup_tag1), .lookup_tag2(lookup_tag2),
      .lookup_data1(lookup_data1), .lookup_data2(lookup_data2),
      .we(we), .write_reg(write_reg), .write_tag(write_tag), .write_data(write_data),
      .mispred(mispred), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [5:0]  rd;
      logic        cv;
      logic [5:0]  ct;
      logic [31:0] cd;
      logic [5:0]  lt;
      logic [32:0] elk;
      logic        ewe;
      logic [5:0]  ereg;
      logic [5:0]  etag;
      logic [31:0] edata;
      logic [5:0]  efree;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [32:0] lk_exp(input logic [32:0] bypass_val);
`ifdef ROB_BYPASS_EN
      return bypass_val;
`else
      return PENDING;
`endif
   endfunction

   task automatic idle();
      dc_valid    = 1'b0;
      dc_rd       = 6'd0;
      cdb_valid   = 1'b0;
      cdb_tag     = 6'd0;
      cdb_data    = 32'd0;
      cdb_mispred = 1'b0;
      cdb_target  = 32'd0;
      lookup_tag1 = 6'd0;
      lookup_tag2 = 6'd0;
   endtask

   task automatic cdb(input logic [5:0] t, input logic [31:0] d, input logic m, input logic [31:0] tgt);
      cdb_valid   = 1'b1;
      cdb_tag     = t;
      cdb_data    = d;
      cdb_mispred = m;
      cdb_target  = tgt;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_free"},  64'(rob_free_entry), 64'd0);
      check({tag, "_full"},  64'(rob_full),       64'd0);
      check({tag, "_we"},    64'(we),             64'd0);
      check({tag, "_mp"},    64'(mispred),        64'd0);
      check({tag, "_wreg"},  64'(write_reg),      64'd0);
      check({tag, "_wtag"},  64'(write_tag),      64'd0);
      check({tag, "_wdata"}, 64'(write_data),     64'd0);
      check({tag, "_rpc"},   64'(redirect_pc),    64'd0);
   endtask

   initial begin
      // dispatch rd 1,2,3 then CDB tags 2,0,1 -> commits of tags 0,1,2 in order
      vecs[0] = '{1'b1, 6'd1, 1'b0, 6'd0, 32'h0,  6'd0, PENDING,            1'b0, 6'd0, 6'd0, 32'h0,  6'd0};
      vecs[1] = '{1'b1, 6'd2, 1'b0, 6'd0, 32'h0,  6'd0, PENDING,            1'b0, 6'd0, 6'd0, 32'h0,  6'd1};
      vecs[2] = '{1'b1, 6'd3, 1'b0, 6'd0, 32'h0,  6'd1, PENDING,            1'b0, 6'd0, 6'd0, 32'h0,  6'd2};
      vecs[3] = '{1'b0, 6'd0, 1'b1, 6'd2, 32'h22, 6'd2, 33'h0_0000_0022,    1'b0, 6'd0, 6'd0, 32'h0,  6'd3};
      vecs[4] = '{1'b0, 6'd0, 1'b1, 6'd0, 32'h10, 6'd2, 33'h0_0000_0022,    1'b0, 6'd0, 6'd0, 32'h0,  6'd3};
      vecs[5] = '{1'b0, 6'd0, 1'b1, 6'd1, 32'h11, 6'd0, 33'h0_0000_0010,    1'b1, 6'd1, 6'd0, 32'h10, 6'd3};
      vecs[6] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'h0,  6'd0, PENDING,            1'b1, 6'd2, 6'd1, 32'h11, 6'd3};
      vecs[7] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'h0,  6'd1, PENDING,            1'b1, 6'd3, 6'd2, 32'h22, 6'd3};
      vecs[8] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'h0,  6'd2, PENDING,            1'b0, 6'd0, 6'd0, 32'h0,  6'd3};

      idle();
      reset = 1'b1;
      @(negedge clk);
      #1 check_reset_outputs("reset");
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         idle();
         dc_valid    = vecs[i].dv;
         dc_rd       = vecs[i].rd;
         cdb_valid   = vecs[i].cv;
         cdb_tag     = vecs[i].ct;
         cdb_data    = vecs[i].cd;
         lookup_tag1 = vecs[i].lt;
         #1;
         check($sformatf("v%0d_we", i),    64'(we),             64'(vecs[i].ewe));
         check($sformatf("v%0d_wreg", i),  64'(write_reg),      64'(vecs[i].ereg));
         check($sformatf("v%0d_wtag", i),  64'(write_tag),      64'(vecs[i].etag));
         check($sformatf("v%0d_wdata", i), 64'(write_data),     64'(vecs[i].edata));
         check($sformatf("v%0d_free", i),  64'(rob_free_entry), 64'(vecs[i].efree));
         check($sformatf("v%0d_full", i),  64'(rob_full),       64'd0);
         check($sformatf("v%0d_lk1", i),   64'(lookup_data1),   64'(lk_exp(vecs[i].elk)));
         @(negedge clk);
      end

      // Fill all 64 entries, refuse while full even alongside a commit, then wrap to tag 0.
      do_reset();
      for (int i = 0; i < 64; i++) begin
         idle();
         dc_valid = 1'b1;
         dc_rd    = 6'(i + 1);
         #1;
         check($sformatf("fill%0d_free", i), 64'(rob_free_entry), 64'(i));
         check($sformatf("fill%0d_full", i), 64'(rob_full),       64'd0);
         @(negedge clk);
      end
      idle();
      dc_valid = 1'b1;
      dc_rd    = 6'h2a;
      #1;
      check("full65_full", 64'(rob_full),       64'd1);
      check("full65_free", 64'(rob_free_entry), 64'd0);
      @(negedge clk);
      idle();
      cdb(6'd0, 32'h55, 1'b0, 32'd0);
      #1;
      check("full_cdb_full", 64'(rob_full), 64'd1);
      check("full_cdb_we",   64'(we),       64'd0);
      @(negedge clk);
      idle();
      dc_valid = 1'b1;
      dc_rd    = 6'd9;
      #1;
      check("full_commit_we",    64'(we),         64'd1);
      check("full_commit_wtag",  64'(write_tag),  64'd0);
      check("full_commit_wreg",  64'(write_reg),  64'd1);
      check("full_commit_wdata", 64'(write_data), 64'h55);
      check("full_commit_full",  64'(rob_full),   64'd1);
      @(negedge clk);
      #1;
      check("wrap_full", 64'(rob_full),       64'd0);
      check("wrap_free", 64'(rob_free_entry), 64'd0);
      check("wrap_we",   64'(we),             64'd0);
      @(negedge clk);
      idle();
      #1;
      check("wrap_after_free", 64'(rob_free_entry), 64'd1);
      check("wrap_after_full", 64'(rob_full),       64'd1);

      // Mispredicted branch at tag 4 flushes everything, discarding same-cycle dispatch and CDB.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         idle();
         dc_valid = 1'b1;
         dc_rd    = 6'(i + 1);
         @(negedge clk);
      end
      idle();
      cdb(6'd5, 32'hDEADBEEF, 1'b0, 32'd0);
      lookup_tag1 = 6'd5;
      lookup_tag2 = 6'd4;
      #1;
      check("fwd_lk1", 64'(lookup_data1), 64'(lk_exp(33'h0_DEAD_BEEF)));
      check("fwd_lk2", 64'(lookup_data2), 64'(PENDING));
      @(negedge clk);
      idle();
      cdb(6'd4, 32'h44, 1'b1, 32'h100);
      lookup_tag2 = 6'd5;
      #1;
      check("done_lk2", 64'(lookup_data2), 64'(lk_exp(33'h0_DEAD_BEEF)));
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         idle();
         if (i < 4) cdb(6'(i), 32'hA0 + 32'(i), 1'b0, 32'h0);
         #1;
         if (i == 0) begin
            check("mp_pre_we", 64'(we), 64'd0);
         end else begin
            check($sformatf("mp_c%0d_wtag", i),  64'(write_tag),  64'(i - 1));
            check($sformatf("mp_c%0d_wreg", i),  64'(write_reg),  64'(i));
            check($sformatf("mp_c%0d_wdata", i), 64'(write_data), 64'(32'hA0 + 32'(i - 1)));
            check($sformatf("mp_c%0d_mp", i),    64'(mispred),    64'd0);
         end
         @(negedge clk);
      end
      idle();
      dc_valid = 1'b1;
      dc_rd    = 6'd7;
      cdb(6'd5, 32'h1234, 1'b0, 32'd0);
      #1;
      check("flush_we",    64'(we),          64'd1);
      check("flush_mp",    64'(mispred),     64'd1);
      check("flush_rpc",   64'(redirect_pc), 64'h100);
      check("flush_wtag",  64'(write_tag),   64'd4);
      check("flush_wreg",  64'(write_reg),   64'd5);
      check("flush_wdata", 64'(write_data),  64'h44);
      @(negedge clk);
      idle();
      lookup_tag1 = 6'd5;
      #1;
      check_reset_outputs("post_flush");
      check("post_flush_lk1", 64'(lookup_data1), 64'(PENDING));

      // Reset with 10 entries in flight; a later CDB to an old tag must not commit.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         idle();
         dc_valid = 1'b1;
         dc_rd    = 6'(i + 1);
         @(negedge clk);
      end
      idle();
      cdb(6'd0, 32'h77, 1'b0, 32'd0);
      @(negedge clk);
      idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cdb(6'd1, 32'h88, 1'b0, 32'd0);
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      idle();
      #1;
      check("midreset_old_tag_we", 64'(we),             64'd0);
      check("midreset_old_free",   64'(rob_free_entry), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular 64-tag reorder buffer between decode/dispatch and the architectural register file. Allocates one tag per dispatched instruction, collects results from the common data bus (CDB), and retires completed entries strictly in program order. Retirement drives the register file write port (`we`, `write_reg`, `write_tag`, `write_data`) and the pipeline-wide `mispred` flush. Tags issued on `rob_free_entry` are the tags the register file records against renamed destinations.

## Interface
- `ENTRIES`, 64: number of entries. Must be a power of two, 2..64. Tags are always 6 bits; the upper tag bits are 0 when `ENTRIES` < 64.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dc_valid`  in  1  dispatch request.
- `dc_rd`  in  6  destination architectural register; 0 means none.
- `rob_free_entry`  out  6  tag allocated to a dispatch this cycle (tail pointer).
- `rob_full`  out  1  no free entry; dispatch is refused.
- `cdb_valid`  in  1  result broadcast.
- `cdb_tag`  in  6  tag of the result.
- `cdb_data`  in  32  result value.
- `cdb_mispred`  in  1  the branch at `cdb_tag` resolved mispredicted.
- `cdb_target`  in  32  correct PC for a mispredicted branch.
- `lookup_tag1`, `lookup_tag2`  in  6  operand tags, from the register file read tags.
- `lookup_data1`, `lookup_data2`  out  33  `{pending, value}`; bit 32 = 1 means not yet available.
- `we`  out  1  commit this cycle.
- `write_reg`  out  6  committed destination register.
- `write_tag`  out  6  committed tag.
- `write_data`  out  32  committed value.
- `mispred`  out  1  committing a mispredicted branch; flush.
- `redirect_pc`  out  32  fetch redirect target, valid while `mispred` = 1.

## Operation
- State:
  - `head` and `tail`: 6-bit pointers that wrap modulo `ENTRIES`.
  - `count`: 7 bits, range 0..`ENTRIES`.
  - Per entry: `valid`, `done`, `mp`, `rd[5:0]`, `data[31:0]`, `target[31:0]`.
- Dispatch is accepted when `dc_valid & ~rob_full`.
  - Entry `tail` gets `valid` = 1, `done` = 0, `mp` = 0, `rd` = `dc_rd`.
  - `tail` increments.
  - `rob_free_entry` = `tail`; `rob_full` = (`count` == `ENTRIES`).
- CDB write occurs when `cdb_valid` and entry `cdb_tag` is valid.
  - The entry gets `done` = 1, `data` = `cdb_data`, `mp` = `cdb_mispred`, `target` = `cdb_target`.
  - A CDB write to an invalid entry is ignored.
- Commit occurs when `count` != 0 and `done[head]` = 1.
  - Outputs: `we` = 1, `write_reg` = `rd[head]`, `write_tag` = `head`, `write_data` = `data[head]`.
  - The entry is cleared and `head` increments.
  - Commit is combinational from registered state, so `write_*` change only on clock edges.
  - When not committing, `we` = 0 and all `write_*` outputs = 0.
- Commit with `mp[head]` = 1:
  - `mispred` = 1 and `redirect_pc` = `target[head]`, in the same cycle as `we`.
  - At that clock edge all entries are invalidated and `head` = `tail` = `count` = 0.
  - A dispatch and a CDB write in the same cycle are both discarded.
- Lookup returns `{0, data[t]}` when entry t is valid and done, or when `cdb_valid & cdb_tag == t` (same-cycle CDB forward). Otherwise it returns `{1, 32'd0}`.
- `count` update: +1 on dispatch, -1 on commit, unchanged when both occur; forced to 0 on flush.

## Timing
- Reset values: `head` = `tail` = `count` = 0, all `valid` = 0.
  - `rob_free_entry` = 0, `rob_full` = 0, `we` = 0, `mispred` = 0, `write_*` = 0, `redirect_pc` = 0.
- Reset mid-operation discards every in-flight entry on that edge.
- Latency:
  - A dispatch at edge N is visible to the CDB from cycle N+1.
  - A CDB write at edge N can commit in cycle N+1, if the entry is at head.
  - Lookup forwarding is combinational (zero cycle).
- One dispatch, one CDB write and one commit per cycle. All three may coincide.
- Full with a simultaneous commit: dispatch is still refused that cycle, because `rob_full` comes from registered `count`.
- Empty: no commit. A CDB write to the entry committing this cycle is not possible, because that entry is already done.
- Wrap-around: `tail` goes from `ENTRIES`-1 to 0 with no bubble.

## Configuration
- `ROB_BYPASS_EN`:
  - Defined: lookup ports behave as described in Operation.
  - Undefined: `lookup_data1` and `lookup_data2` are tied to `{1, 32'd0}`. Operands then wait for the CDB or register file, and the ROB data lookup muxes are not synthesized.

## Test plan
- Three dispatches (rd = 1, 2, 3), then CDB for tags 2, 0, 1 in that order -> commits in order of tags 0, 1, 2. `write_reg` = 1, 2, 3 and `write_data` matches the CDB values.
- 64 dispatches with no CDB -> `rob_full` = 1 and the 65th dispatch is refused. CDB tag 0, then dispatch in the cycle the commit happens -> refused. The next cycle -> accepted with tag 0 (wrap).
- Tag 4 completes with `cdb_mispred` = 1, `cdb_target` = 0x100 -> when tag 4 reaches head, `we` = `mispred` = 1 and `redirect_pc` = 0x100. The next cycle `count` = 0 and `rob_free_entry` = 0.
- With `ROB_BYPASS_EN`: `lookup_tag1` = 5 while CDB tag 5 data = 0xDEADBEEF -> `lookup_data1` = {0, 0xDEADBEEF} in the same cycle. Without the macro -> {1, 0}.
- `reset` asserted with 10 entries in flight -> the next cycle all outputs are at reset values, and a CDB to an old tag causes no commit.
